// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions the three raw board pushbuttons for the Connect Four game top.
// Each button is synchronized (2 FF) and debounced. Each accepted press then
// becomes a one-cycle pulse:
//   - right/left : one pulse on press, auto-repeat while held.
//                  Pressing both at once locks out both outputs.
//   - drop       : one pulse per press, never repeats.
//
// Ports
//   clk_25MHz      in   single system clock
//   rst_n          in   asynchronous active-low reset
//   btn_right_raw  in   raw right button, active-high, asynchronous
//   btn_left_raw   in   raw left button, active-high, asynchronous
//   btn_drop_raw   in   raw drop button, active-high, asynchronous
//   move_right     out  one-cycle pulse per accepted right step
//   move_left      out  one-cycle pulse per accepted left step
//   drop_piece     out  one-cycle pulse per drop press
//   btn_level      out  debounced stable levels {drop, left, right}
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,   // must be >= 2
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 3750000
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       btn_right_raw,
  input  logic       btn_left_raw,
  input  logic       btn_drop_raw,
  output logic       move_right,
  output logic       move_left,
  output logic       drop_piece,
  output logic [2:0] btn_level
);

  // Button index inside the 3-bit vectors: 0 = right, 1 = left, 2 = drop.
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DROP  = 2;

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  // Keep the timer at least one bit wide when both repeat intervals are 1.
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } move_state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  logic [2:0] r_s1;
  logic [2:0] r_s2;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      // NOTE: non-blocking assignments let r_s2 take the old r_s1, forming a
      // real two-stage chain; blocking would collapse it into one flop.
      r_s1 <= {btn_drop_raw, btn_left_raw, btn_right_raw};
      r_s2 <= r_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: a level is accepted once it has differed from the stable level
  // for DEBOUNCE_CYCLES consecutive synchronized cycles.
  // ---------------------------------------------------------------------------
  logic [2:0]    r_stb;
  logic [CW-1:0] r_cnt     [3];
  logic [2:0]    w_stb_nxt;
  logic [CW-1:0] w_cnt_nxt [3];
  logic [2:0]    w_rise;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the branches can leave a value held (no latch).
      w_stb_nxt[i] = r_stb[i];
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_stb[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_stb_nxt[i] = ~r_stb[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // The pulse logic works on the next stable level, so a pulse is registered
  // on the same edge that the stable level changes.
  assign w_rise = w_stb_nxt & ~r_stb;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_stb <= '0;
      // NOTE: the counter array is a small set of control flops, not a RAM,
      // so every entry is reset; a stale count would corrupt the first press.
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_stb <= w_stb_nxt;
      for (int i = 0; i < 3; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Move FSMs (g = 0 right, g = 1 left)
  // ---------------------------------------------------------------------------
  // Both move buttons held: both FSMs are forced idle and stay silent.
  logic       w_lock;
  logic [1:0] w_move_pulse;

  assign w_lock = w_stb_nxt[BTN_RIGHT] & w_stb_nxt[BTN_LEFT];

  for (genvar g = 0; g < 2; g++) begin : g_move
    move_state_t   r_state;
    move_state_t   w_state_nxt;
    logic [TW-1:0] r_tmr;
    logic [TW-1:0] w_tmr_nxt;
    logic          w_pulse;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_IDLE;
        r_tmr   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_tmr   <= w_tmr_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = '0;
      w_pulse     = 1'b0;
      if (!w_stb_nxt[g] || w_lock) begin
        w_state_nxt = ST_IDLE;
      end else begin
        case (r_state)
          // Held with no rising edge only happens when the other button
          // leaves lockout: start the delay silently in that case.
          ST_IDLE: begin
            w_state_nxt = ST_DELAY;
            w_pulse     = w_rise[g];
          end
          ST_DELAY: begin
            if (r_tmr == DELAY_LAST) begin
              w_state_nxt = ST_REPEAT;
              w_pulse     = 1'b1;
            end else begin
              w_tmr_nxt = r_tmr + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (r_tmr == PERIOD_LAST) begin
              w_pulse = 1'b1;
            end else begin
              w_tmr_nxt = r_tmr + 1'b1;
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end

    assign w_move_pulse[g] = w_pulse;
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic r_move_right;
  logic r_move_left;
  logic r_drop_piece;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_move_right <= 1'b0;
      r_move_left  <= 1'b0;
      r_drop_piece <= 1'b0;
    end else begin
      r_move_right <= w_move_pulse[BTN_RIGHT];
      r_move_left  <= w_move_pulse[BTN_LEFT];
      r_drop_piece <= w_rise[BTN_DROP];
    end
  end

  assign move_right = r_move_right;
  assign move_left  = r_move_left;
  assign drop_piece = r_drop_piece;
  assign btn_level  = r_stb;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8. Inputs change on the falling edge, so the
// next rising edge is "edge 1". A monitor logs the edge number of every pulse.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  logic       clk_25MHz;
  logic       rst_n;
  logic       btn_right_raw;
  logic       btn_left_raw;
  logic       btn_drop_raw;
  logic       move_right;
  logic       move_left;
  logic       drop_piece;
  logic [2:0] btn_level;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;     // number of rising edges seen so far

  int q_right [$];
  int q_left  [$];
  int q_drop  [$];
  logic [2:0] level_seen;

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk_25MHz     (clk_25MHz),
    .rst_n         (rst_n),
    .btn_right_raw (btn_right_raw),
    .btn_left_raw  (btn_left_raw),
    .btn_drop_raw  (btn_drop_raw),
    .move_right    (move_right),
    .move_left     (move_left),
    .drop_piece    (drop_piece),
    .btn_level     (btn_level)
  );

  initial clk_25MHz = 1'b0;
  always #5 clk_25MHz = ~clk_25MHz;

  always @(posedge clk_25MHz) cyc <= cyc + 1;

  // Log pulses shortly after the edge that produced them.
  always @(posedge clk_25MHz) begin
    #1;
    if (move_right) q_right.push_back(cyc);
    if (move_left)  q_left.push_back(cyc);
    if (drop_piece) q_drop.push_back(cyc);
    level_seen = level_seen | btn_level;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int edge_no);
    while (cyc < edge_no) @(negedge clk_25MHz);
  endtask

  task automatic clear_logs();
    q_right.delete();
    q_left.delete();
    q_drop.delete();
    level_seen = '0;
  endtask

  initial begin
    int t;
    int tr;
    int idx;
    int rep_off [7];

    rep_off = '{0, 20, 28, 36, 44, 52, 60};
    level_seen    = '0;
    rst_n         = 1'b0;
    btn_right_raw = 1'b0;
    btn_left_raw  = 1'b0;
    btn_drop_raw  = 1'b0;

    // ---- Reset state
    repeat (3) @(negedge clk_25MHz);
    check("rst_move_right", 32'(move_right), 0);
    check("rst_move_left",  32'(move_left),  0);
    check("rst_drop_piece", 32'(drop_piece), 0);
    check("rst_btn_level",  32'(btn_level),  0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_25MHz);
    clear_logs();

    // ---- Clean drop press: pulse at edge 6, level held until 6 edges after release
    t = cyc;
    btn_drop_raw = 1'b1;
    wait_until(t + 5);
    check("drop_e5_pulse", 32'(drop_piece), 0);
    check("drop_e5_level", 32'(btn_level),  0);
    wait_until(t + 6);
    check("drop_e6_pulse", 32'(drop_piece), 1);
    check("drop_e6_level", 32'(btn_level),  32'b100);
    wait_until(t + 7);
    check("drop_e7_pulse", 32'(drop_piece), 0);
    wait_until(t + 50);
    btn_drop_raw = 1'b0;
    tr = cyc;
    wait_until(tr + 5);
    check("drop_rel_e5_level", 32'(btn_level), 32'b100);
    wait_until(tr + 6);
    check("drop_rel_e6_level", 32'(btn_level), 0);
    wait_until(tr + 12);
    check("drop_count", q_drop.size(), 1);
    if (q_drop.size() > 0) check("drop_time", q_drop[0], t + 6);
    check("drop_no_moves", q_right.size() + q_left.size(), 0);

    // ---- Bounce: 2-cycle toggles for 20 cycles, then settle high
    clear_logs();
    for (int k = 0; k < 10; k++) begin
      btn_drop_raw = ~k[0];
      repeat (2) @(negedge clk_25MHz);
    end
    check("bounce_no_pulse", q_drop.size(), 0);
    check("bounce_no_level", 32'(level_seen), 0);
    t = cyc;
    btn_drop_raw = 1'b1;
    wait_until(t + 12);
    check("bounce_count", q_drop.size(), 1);
    if (q_drop.size() > 0) check("bounce_time", q_drop[0], t + 6);
    btn_drop_raw = 1'b0;
    wait_until(cyc + 10);

    // ---- Glitch: right high for 3 cycles is discarded
    clear_logs();
    btn_right_raw = 1'b1;
    repeat (3) @(negedge clk_25MHz);
    btn_right_raw = 1'b0;
    repeat (10) @(negedge clk_25MHz);
    check("glitch_no_pulse", q_right.size(), 0);
    check("glitch_no_level", 32'(level_seen), 0);

    // ---- Auto-repeat. Raw held 66 cycles so the stable level falls at t+72,
    // after the t0+60 pulse and before the t0+68 one would be due.
    clear_logs();
    t = cyc;
    btn_right_raw = 1'b1;
    wait_until(t + 66);
    btn_right_raw = 1'b0;
    wait_until(t + 100);
    check("repeat_count", q_right.size(), 7);
    for (int k = 0; k < 7; k++) begin
      if (k < q_right.size()) check($sformatf("repeat_time_%0d", k), q_right[k], t + 6 + rep_off[k]);
    end
    check("repeat_no_left", q_left.size(), 0);
    check("repeat_level_low", 32'(btn_level), 0);

    // ---- Lockout: simultaneous press gives nothing; releasing right starts
    // left's delay silently from the edge right's stable level falls.
    clear_logs();
    t = cyc;
    btn_right_raw = 1'b1;
    btn_left_raw  = 1'b1;
    wait_until(t + 6);
    check("lock_level", 32'(btn_level), 32'b011);
    wait_until(t + 30);
    check("lock_no_right", q_right.size(), 0);
    check("lock_no_left",  q_left.size(),  0);
    btn_right_raw = 1'b0;
    tr = cyc + 6;                    // edge where right's stable level falls
    wait_until(tr);
    check("lock_right_released", 32'(btn_level), 32'b010);
    wait_until(tr + 38);             // left's stable level then falls at tr+44
    btn_left_raw = 1'b0;
    wait_until(tr + 60);
    check("lock_left_count", q_left.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < q_left.size()) check($sformatf("lock_left_time_%0d", k), q_left[k], tr + 20 + 8 * k);
    end
    check("lock_right_after", q_right.size(), 0);

    // ---- Reset mid-repeat
    clear_logs();
    t = cyc;
    btn_right_raw = 1'b1;
    wait_until(t + 34);              // second repeat pulse (t0+28) is high now
    check("mid_pulse_high", 32'(move_right), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pulse", 32'(move_right), 0);
    check("mid_rst_level", 32'(btn_level),  0);
    repeat (3) @(negedge clk_25MHz);
    clear_logs();
    rst_n = 1'b1;
    tr = cyc;
    wait_until(tr + 36);             // level then falls at tr+42, no pulse there
    btn_right_raw = 1'b0;
    wait_until(tr + 55);
    check("post_rst_count", q_right.size(), 3);
    idx = 0;
    foreach (q_right[k]) begin
      if (k < 3) check($sformatf("post_rst_time_%0d", k), q_right[k], tr + 6 + rep_off[k]);
      idx++;
    end
    check("post_rst_no_drop", q_drop.size() + q_left.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
